// File: rtl/condicionador_botoes.sv
// Button conditioner: synchronises the 9 raw board buttons, debounces them
// and forwards only single-button presses as a held one-hot vector.
module condicionador_botoes #(
    parameter int unsigned DEBOUNCE_CICLOS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [8:0] botoes_raw,
    output logic [8:0] botoes,
    output logic       jogada_valida,
    output logic       erro_multipla,
    output logic [1:0] db_estado
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        FILTRA  = 2'b01,
        ESTAVEL = 2'b10,
        LIBERA  = 2'b11
    } estado_t;

    logic [8:0]    sync1_q, sync2_q;
    logic [8:0]    amostra_q, amostra_d;
    logic [CW-1:0] cnt_q, cnt_d;
    estado_t       estado_q, estado_d;
    logic [8:0]    botoes_q, botoes_d;
    logic          valida_q, valida_d;
    logic          erro_q, erro_d;
    logic          um_so_botao;

    // Exactly one bit set in the filtered sample
    assign um_so_botao = (amostra_q != '0) && ((amostra_q & (amostra_q - 9'd1)) == '0);

    // Next-state and output decisions of the press/release filter
    always_comb begin
        amostra_d = amostra_q;
        cnt_d     = cnt_q;
        estado_d  = estado_q;
        botoes_d  = botoes_q;
        valida_d  = 1'b0;
        erro_d    = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (habilita && (sync2_q != '0)) begin
                    amostra_d = sync2_q;
                    cnt_d     = '0;
                    estado_d  = FILTRA;
                end
            end
            FILTRA: begin
                if (sync2_q == '0) begin
                    estado_d = OCIOSO;
                end else if (sync2_q != amostra_q) begin
                    amostra_d = sync2_q;
                    cnt_d     = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (um_so_botao) begin
                    botoes_d = amostra_q;
                    valida_d = 1'b1;
                    estado_d = ESTAVEL;
                end else begin
                    erro_d   = 1'b1;
                    cnt_d    = '0;
                    estado_d = LIBERA;
                end
            end
            ESTAVEL: begin
                if (sync2_q != amostra_q) begin
                    botoes_d = '0;
                    cnt_d    = '0;
                    estado_d = LIBERA;
                end
            end
            default: begin
                botoes_d = '0;
                if (sync2_q != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = OCIOSO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Synchroniser chain, filter state and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            amostra_q <= '0;
            cnt_q     <= '0;
            estado_q  <= OCIOSO;
            botoes_q  <= '0;
            valida_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            sync1_q   <= botoes_raw;
            sync2_q   <= sync1_q;
            amostra_q <= amostra_d;
            cnt_q     <= cnt_d;
            estado_q  <= estado_d;
            botoes_q  <= botoes_d;
            valida_q  <= valida_d;
            erro_q    <= erro_d;
        end
    end

    assign botoes        = botoes_q;
    assign jogada_valida = valida_q;
    assign erro_multipla = erro_q;
    assign db_estado     = estado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: directed scenarios plus random hold patterns,
// all checked against a sample-history reference model.
module tb_condicionador_botoes;

    localparam int D = 4;
    localparam int PH_IDLE = 0, PH_FILTER = 1, PH_HOLD = 2, PH_DRAIN = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [8:0] botoes_raw;
    logic [8:0] botoes;
    logic       jogada_valida;
    logic       erro_multipla;
    logic [1:0] db_estado;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [8:0] m_s1, m_s2, m_cand, m_out;
    logic       m_ok, m_err;
    logic [1:0] m_db;
    int         m_mode, m_seen, m_zeros;

    condicionador_botoes #(.DEBOUNCE_CICLOS(D)) dut (
        .clock        (clock),
        .reset        (reset),
        .habilita     (habilita),
        .botoes_raw   (botoes_raw),
        .botoes       (botoes),
        .jogada_valida(jogada_valida),
        .erro_multipla(erro_multipla),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_cand = '0; m_out = '0;
        m_ok = 1'b0; m_err = 1'b0; m_db = 2'd0;
        m_mode = PH_IDLE; m_seen = 0; m_zeros = 0;
    endtask

    // One clock edge of the model: the filter sees the raw value from two edges ago.
    // m_seen = number of consecutive identical samples, m_zeros = consecutive zero samples.
    task automatic model_step(input logic [8:0] r, input logic h);
        logic [8:0] s;
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = r;
        m_ok = 1'b0;
        m_err = 1'b0;
        case (m_mode)
            PH_IDLE: begin
                if (h && s != 0) begin m_cand = s; m_seen = 1; m_mode = PH_FILTER; end
            end
            PH_FILTER: begin
                if (s == 0) m_mode = PH_IDLE;
                else if (s != m_cand) begin m_cand = s; m_seen = 1; end
                else if (m_seen < D) m_seen++;
                else if ($countones(m_cand) == 1) begin
                    m_out = m_cand; m_ok = 1'b1; m_mode = PH_HOLD;
                end else begin
                    m_err = 1'b1; m_zeros = 0; m_mode = PH_DRAIN;
                end
            end
            PH_HOLD: begin
                if (s != m_cand) begin m_out = '0; m_zeros = 0; m_mode = PH_DRAIN; end
            end
            default: begin
                if (s != 0) m_zeros = 0;
                else begin
                    m_zeros++;
                    if (m_zeros == D) m_mode = PH_IDLE;
                end
            end
        endcase
        m_db = 2'(m_mode);
    endtask

    // Advance one cycle: inputs are stable across the rising edge, outputs read at the falling edge
    task automatic tick();
        @(posedge clock);
        if (reset) model_step(botoes_raw, habilita);
        @(negedge clock);
    endtask

    task automatic idle_wait(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({botoes, jogada_valida, erro_multipla, db_estado} !== 13'd0)
            begin bad++; $display("FAIL reset_outputs: got b=%h v=%b e=%b st=%0d want all 0", botoes, jogada_valida, erro_multipla, db_estado); end
        habilita = 1'b1;
        botoes_raw = 9'h010;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({botoes, jogada_valida, erro_multipla, db_estado} !== 13'd0)
                begin bad++; $display("FAIL reset_held: got b=%h v=%b e=%b st=%0d want all 0", botoes, jogada_valida, erro_multipla, db_estado); end
        end
        botoes_raw = '0;
        reset = 1'b1;
        idle_wait(4);
        total++;
        if (db_estado !== 2'd0) begin bad++; $display("FAIL reset_idle: got st=%0d want 0", db_estado); end
    endtask

    task automatic test_clean_press();
        logic [8:0] exp_b;
        habilita = 1'b1;
        botoes_raw = 9'h010;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_b = (i >= 7) ? 9'h010 : 9'h000;
            total++;
            if ({botoes, jogada_valida} !== {exp_b, i == 7})
                begin bad++; $display("FAIL clean_press t%0d: got b=%h v=%b want b=%h v=%b", i, botoes, jogada_valida, exp_b, i == 7); end
            total++;
            if ({botoes, jogada_valida, erro_multipla, db_estado} !== {m_out, m_ok, m_err, m_db})
                begin bad++; $display("FAIL clean_model t%0d: got b=%h v=%b e=%b st=%0d want b=%h v=%b e=%b st=%0d", i, botoes, jogada_valida, erro_multipla, db_estado, m_out, m_ok, m_err, m_db); end
        end
        botoes_raw = '0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i <= 2) begin
                total++;
                if (botoes !== 9'h010) begin bad++; $display("FAIL release_hold t%0d: got b=%h want 010", i, botoes); end
            end
            if (i == 3) begin
                total++;
                if (botoes !== 9'h000) begin bad++; $display("FAIL release_drop: got b=%h want 000", botoes); end
            end
            total++;
            if ({botoes, jogada_valida, erro_multipla, db_estado} !== {m_out, m_ok, m_err, m_db})
                begin bad++; $display("FAIL release_model t%0d: got b=%h st=%0d want b=%h st=%0d", i, botoes, db_estado, m_out, m_db); end
        end
        total++;
        if (db_estado !== 2'd0) begin bad++; $display("FAIL release_idle: got st=%0d want 0", db_estado); end
    endtask

    task automatic test_bounce();
        logic [8:0] pat [10];
        pat = '{9'h004, 9'h004, 9'h000, 9'h000, 9'h004, 9'h004, 9'h000, 9'h000, 9'h004, 9'h004};
        for (int n = 1; n <= 20; n++) begin
            botoes_raw = (n <= 10) ? pat[n-1] : 9'h004;
            tick();
            total++;
            if (jogada_valida !== (n == 15))
                begin bad++; $display("FAIL bounce_pulse t%0d: got v=%b want %b", n, jogada_valida, n == 15); end
            total++;
            if ({botoes, jogada_valida, erro_multipla, db_estado} !== {m_out, m_ok, m_err, m_db})
                begin bad++; $display("FAIL bounce_model t%0d: got b=%h st=%0d want b=%h st=%0d", n, botoes, db_estado, m_out, m_db); end
        end
        total++;
        if (botoes !== 9'h004) begin bad++; $display("FAIL bounce_held: got b=%h want 004", botoes); end
        botoes_raw = '0;
        idle_wait(10);
    endtask

    task automatic test_multi();
        botoes_raw = 9'h003;
        for (int n = 1; n <= 7; n++) begin
            tick();
            total++;
            if ({botoes, jogada_valida, erro_multipla} !== {9'h000, 1'b0, n == 7})
                begin bad++; $display("FAIL multi_press t%0d: got b=%h v=%b e=%b want b=000 v=0 e=%b", n, botoes, jogada_valida, erro_multipla, n == 7); end
        end
        botoes_raw = '0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            total++;
            if ({botoes, jogada_valida, erro_multipla, db_estado} !== {m_out, m_ok, m_err, m_db})
                begin bad++; $display("FAIL multi_drain t%0d: got b=%h e=%b st=%0d want b=%h e=%b st=%0d", n, botoes, erro_multipla, db_estado, m_out, m_err, m_db); end
        end
        total++;
        if (db_estado !== 2'd0) begin bad++; $display("FAIL multi_idle: got st=%0d want 0", db_estado); end
        botoes_raw = 9'h100;
        idle_wait(7);
        total++;
        if ({botoes, jogada_valida, erro_multipla} !== {9'h100, 1'b1, 1'b0})
            begin bad++; $display("FAIL multi_after: got b=%h v=%b e=%b want b=100 v=1 e=0", botoes, jogada_valida, erro_multipla); end
        botoes_raw = '0;
        idle_wait(10);
    endtask

    task automatic test_extra_button();
        botoes_raw = 9'h001;
        idle_wait(9);
        total++;
        if (botoes !== 9'h001) begin bad++; $display("FAIL extra_setup: got b=%h want 001", botoes); end
        botoes_raw = 9'h081;
        for (int n = 1; n <= 13; n++) begin
            tick();
            total++;
            if ({botoes, jogada_valida, erro_multipla} !== {(n <= 2) ? 9'h001 : 9'h000, 2'b00})
                begin bad++; $display("FAIL extra_drop t%0d: got b=%h v=%b e=%b", n, botoes, jogada_valida, erro_multipla); end
        end
        botoes_raw = '0;
        idle_wait(8);
        botoes_raw = 9'h001;
        for (int n = 1; n <= 7; n++) begin
            tick();
            total++;
            if ({botoes, jogada_valida, erro_multipla, db_estado} !== {m_out, m_ok, m_err, m_db})
                begin bad++; $display("FAIL extra_repress t%0d: got b=%h v=%b st=%0d want b=%h v=%b st=%0d", n, botoes, jogada_valida, db_estado, m_out, m_ok, m_db); end
        end
        total++;
        if ({botoes, jogada_valida} !== {9'h001, 1'b1})
            begin bad++; $display("FAIL extra_accept: got b=%h v=%b want b=001 v=1", botoes, jogada_valida); end
        botoes_raw = '0;
        idle_wait(10);
    endtask

    task automatic test_habilita();
        habilita = 1'b0;
        botoes_raw = 9'h020;
        for (int n = 1; n <= 20; n++) begin
            tick();
            total++;
            if ({botoes, jogada_valida, erro_multipla, db_estado} !== 13'd0)
                begin bad++; $display("FAIL hab_blocked t%0d: got b=%h v=%b e=%b st=%0d want all 0", n, botoes, jogada_valida, erro_multipla, db_estado); end
        end
        habilita = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            total++;
            if (jogada_valida !== (n == 1 + D))
                begin bad++; $display("FAIL hab_pulse t%0d: got v=%b want %b", n, jogada_valida, n == 1 + D); end
        end
        total++;
        if (botoes !== 9'h020) begin bad++; $display("FAIL hab_accept: got b=%h want 020", botoes); end
        habilita = 1'b0;
        idle_wait(3);
        total++;
        if (botoes !== 9'h020) begin bad++; $display("FAIL hab_drop_hold: got b=%h want 020", botoes); end
        botoes_raw = '0;
        for (int n = 1; n <= 9; n++) begin
            tick();
            total++;
            if ({botoes, db_estado} !== {m_out, m_db})
                begin bad++; $display("FAIL hab_release t%0d: got b=%h st=%0d want b=%h st=%0d", n, botoes, db_estado, m_out, m_db); end
        end
        habilita = 1'b1;
    endtask

    task automatic test_reset_mid();
        botoes_raw = 9'h040;
        idle_wait(9);
        total++;
        if ({botoes, db_estado} !== {9'h040, 2'd2})
            begin bad++; $display("FAIL rstmid_setup: got b=%h st=%0d want b=040 st=2", botoes, db_estado); end
        #3 reset = 1'b0;
        #1;
        model_reset();
        total++;
        if ({botoes, jogada_valida, erro_multipla, db_estado} !== 13'd0)
            begin bad++; $display("FAIL rstmid_async: got b=%h st=%0d want b=000 st=0", botoes, db_estado); end
        @(negedge clock);
        tick();
        reset = 1'b1;
        botoes_raw = '0;
        idle_wait(6);
        botoes_raw = 9'h040;
        for (int n = 1; n <= 7; n++) begin
            tick();
            total++;
            if ({botoes, jogada_valida} !== {(n == 7) ? 9'h040 : 9'h000, n == 7})
                begin bad++; $display("FAIL rstmid_repress t%0d: got b=%h v=%b", n, botoes, jogada_valida); end
        end
        botoes_raw = '0;
        idle_wait(10);
    endtask

    task automatic test_random();
        int pick, len;
        logic [8:0] val;
        for (int seg = 0; seg < 80; seg++) begin
            pick = $urandom_range(0, 3);
            if (pick == 0) val = '0;
            else if (pick == 3) val = 9'($urandom);
            else val = 9'h001 << $urandom_range(0, 8);
            len = $urandom_range(1, 10);
            habilita = ($urandom_range(0, 7) != 0);
            botoes_raw = val;
            for (int n = 0; n < len; n++) begin
                tick();
                total++;
                if ({botoes, jogada_valida, erro_multipla, db_estado} !== {m_out, m_ok, m_err, m_db})
                    begin bad++; $display("FAIL random_model s%0d: got b=%h v=%b e=%b st=%0d want b=%h v=%b e=%b st=%0d", seg, botoes, jogada_valida, erro_multipla, db_estado, m_out, m_ok, m_err, m_db); end
                total++;
                if (($countones(botoes) > 1) || (jogada_valida && erro_multipla))
                    begin bad++; $display("FAIL random_invariant s%0d: got b=%h v=%b e=%b want onehot0 and exclusive pulses", seg, botoes, jogada_valida, erro_multipla); end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        habilita = 1'b0;
        botoes_raw = '0;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi();
        test_extra_button();
        test_habilita();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
